// File: rtl/ansi_csi_parser_pkg.sv
// Shared character/command codes and byte classifiers for the ANSI CSI parser.
// CHAR_* and CMD_* live here so the text engine and the parser agree on encodings.
package ansi_csi_parser_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] CHAR_ESC       = 8'h1B;
  localparam logic [7:0] CHAR_CSI_INTRO = 8'h5B;  // '['
  localparam logic [7:0] CHAR_SEMI      = 8'h3B;  // ';'

  localparam logic [7:0] CMD_UP         = 8'h81;
  localparam logic [7:0] CMD_DOWN       = 8'h82;
  localparam logic [7:0] CMD_RIGHT      = 8'h83;
  localparam logic [7:0] CMD_LEFT       = 8'h84;
  localparam logic [7:0] CMD_HOME       = 8'h85;
  localparam logic [7:0] CMD_END        = 8'h86;
  localparam logic [7:0] CMD_PGUP       = 8'h87;
  localparam logic [7:0] CMD_PGDN       = 8'h88;
  localparam logic [7:0] CMD_INSTOG     = 8'h89;
  localparam logic [7:0] CMD_DEL        = 8'h8A;
  localparam logic [7:0] CMD_CLS        = 8'h8B;
  localparam logic [7:0] CMD_ERASE_EOL  = 8'h8C;
  localparam logic [7:0] CMD_ERASE_SOL  = 8'h8D;
  localparam logic [7:0] CMD_ERASE_LINE = 8'h8E;
  localparam logic [7:0] CMD_GOTO       = 8'h8F;
  localparam logic [7:0] CMD_SGR        = 8'h90;

  function automatic logic isDigit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic isFinal(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/ansi_csi_parser_rx_fifo.sv
// First-word-fall-through byte FIFO; flush is a synchronous clear of pointers and count.
// A write is accepted only when not full; the head is readable combinationally.
module ansi_rx_fifo
  import ansi_csi_parser_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BYTE_W
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doWr;
  logic             doRd;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doWr   = wrEn & ~full;
  assign doRd   = rdEn & ~empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doWr) mem[wrPtr] <= wrData;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + AW'(1);
      if (doRd) rdPtr <= rdPtr + AW'(1);
      case ({doWr, doRd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ansi_csi_parser.sv
// ANSI/VT100 CSI decoder: buffers rx bytes and emits plain chars or CMD_* tokens with parameters.
// Optional ANSI_SGR_EN: 'm' sequences emit CMD_SGR instead of being swallowed.
module ansi_csi_parser
  import ansi_csi_parser_pkg::*;
#(
  parameter int MAX_PARAMS = 2,
  parameter int PARAM_W    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ESC_TICKS  = 2
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            tick,
  input  logic                            in_valid,
  input  logic [7:0]                      in_data,
  output logic                            in_ready,
  output logic                            in_ovf,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [7:0]                      out_code,
  output logic [MAX_PARAMS*PARAM_W-1:0]   out_params,
  output logic [$clog2(MAX_PARAMS+1)-1:0] out_nparams
);
  localparam int NP_W  = $clog2(MAX_PARAMS+1);
  localparam int TC_W  = $clog2(ESC_TICKS+1);
  localparam int ACC_W = PARAM_W + 4;
  localparam logic [PARAM_W-1:0] PARAM_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_ESC, ST_CSI} parseState_t;

  parseState_t stateReg, stateNext;
  logic [PARAM_W-1:0] paramReg [MAX_PARAMS];
  logic [PARAM_W-1:0] paramNext [MAX_PARAMS];
  logic [NP_W-1:0]    idxReg, idxNext;
  logic               anyReg, anyNext;
  logic [TC_W-1:0]    tickCntReg, tickCntNext, tickSum;
  logic               tickSeenReg;

  logic                          outValidReg;
  logic [7:0]                    outCodeReg;
  logic [MAX_PARAMS*PARAM_W-1:0] outParamsReg;
  logic [NP_W-1:0]               outNparamsReg;

  logic                          emit;
  logic [7:0]                    emitCode;
  logic [MAX_PARAMS*PARAM_W-1:0] emitParams;
  logic [NP_W-1:0]               emitN;

  logic       fifoEmpty, fifoFull, pop, stall, tickEdge, timedOut;
  logic [7:0] headByte;

  logic [PARAM_W-1:0] p0, p1, curParam, accSat;
  logic [ACC_W-1:0]   accum;
  logic [NP_W-1:0]    nGiven;
  logic [7:0]         finCode;
  logic               finCmd, finDrop, def0, def1;
  logic [MAX_PARAMS*PARAM_W-1:0] cmdParams;

  ansi_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(BYTE_W)
  ) rxFifo (
    .clk   (clk),
    .flush (~resetn),
    .wrEn  (in_valid),
    .wrData(in_data),
    .rdEn  (pop),
    .rdData(headByte),
    .empty (fifoEmpty),
    .full  (fifoFull)
  );

  assign in_ready    = ~fifoFull;
  assign in_ovf      = in_valid & fifoFull;
  assign stall       = outValidReg & ~out_ready;
  assign pop         = ~fifoEmpty & ~stall;
  assign tickEdge    = tick & ~tickSeenReg;
  assign out_valid   = outValidReg;
  assign out_code    = outCodeReg;
  assign out_params  = outParamsReg;
  assign out_nparams = outNparamsReg;

  // Parameter bookkeeping: current-slot accumulator, count of given params, timeout tally.
  always_comb begin
    curParam = '0;
    for (int i = 0; i < MAX_PARAMS; i++) begin
      if (NP_W'(i) == idxReg) curParam = paramReg[i];
    end
    accum  = ACC_W'(curParam) * ACC_W'(10) + ACC_W'(headByte[3:0]);
    accSat = (accum > ACC_W'(PARAM_MAX)) ? PARAM_MAX : accum[PARAM_W-1:0];

    if (!anyReg)                             nGiven = '0;
    else if (idxReg >= NP_W'(MAX_PARAMS))    nGiven = NP_W'(MAX_PARAMS);
    else                                     nGiven = idxReg + NP_W'(1);

    if (tickEdge && (tickCntReg != TC_W'(ESC_TICKS))) tickSum = tickCntReg + TC_W'(1);
    else                                              tickSum = tickCntReg;
    timedOut = (tickSum == TC_W'(ESC_TICKS));
  end

  // Final-byte decode; absent or zero params fall back to 1 where the command expects a count.
  always_comb begin
    p0 = paramReg[0];
    p1 = '0;
    for (int i = 1; i < MAX_PARAMS; i++) begin
      if (i == 1) p1 = paramReg[i];
    end
    finCode = headByte;
    finCmd  = 1'b0;
    finDrop = 1'b0;
    def0    = 1'b0;
    def1    = 1'b0;
    case (headByte)
      8'h41: begin finCode = CMD_UP;    finCmd = 1'b1; def0 = 1'b1; end
      8'h42: begin finCode = CMD_DOWN;  finCmd = 1'b1; def0 = 1'b1; end
      8'h43: begin finCode = CMD_RIGHT; finCmd = 1'b1; def0 = 1'b1; end
      8'h44: begin finCode = CMD_LEFT;  finCmd = 1'b1; def0 = 1'b1; end
      8'h48, 8'h66: begin
        finCode = CMD_GOTO; finCmd = 1'b1; def0 = 1'b1; def1 = 1'b1;
      end
      8'h46: begin finCode = CMD_END; finCmd = 1'b1; end
      8'h4A: begin
        if ((p0 == PARAM_W'(2)) || (p0 == PARAM_W'(3))) begin
          finCode = CMD_CLS; finCmd = 1'b1;
        end
      end
      8'h4B: begin
        case (p0)
          PARAM_W'(0): begin finCode = CMD_ERASE_EOL;  finCmd = 1'b1; end
          PARAM_W'(1): begin finCode = CMD_ERASE_SOL;  finCmd = 1'b1; end
          PARAM_W'(2): begin finCode = CMD_ERASE_LINE; finCmd = 1'b1; end
          default: ;
        endcase
      end
      8'h7E: begin
        case (p0)
          PARAM_W'(1), PARAM_W'(7): begin finCode = CMD_HOME;   finCmd = 1'b1; end
          PARAM_W'(2):              begin finCode = CMD_INSTOG; finCmd = 1'b1; end
          PARAM_W'(3):              begin finCode = CMD_DEL;    finCmd = 1'b1; end
          PARAM_W'(4), PARAM_W'(8): begin finCode = CMD_END;    finCmd = 1'b1; end
          PARAM_W'(5):              begin finCode = CMD_PGUP;   finCmd = 1'b1; end
          PARAM_W'(6):              begin finCode = CMD_PGDN;   finCmd = 1'b1; end
          default: ;
        endcase
      end
      8'h6D: begin
`ifdef ANSI_SGR_EN
        finCode = CMD_SGR; finCmd = 1'b1;
`else
        finDrop = 1'b1;
`endif
      end
      default: ;
    endcase

    cmdParams = '0;
    for (int i = 0; i < MAX_PARAMS; i++) begin
      cmdParams[i*PARAM_W +: PARAM_W] = paramReg[i];
      if ((((i == 0) && def0) || ((i == 1) && def1)) && (paramReg[i] == '0))
        cmdParams[i*PARAM_W +: PARAM_W] = PARAM_W'(1);
    end
  end

  always_comb begin
    stateNext   = stateReg;
    paramNext   = paramReg;
    idxNext     = idxReg;
    anyNext     = anyReg;
    tickCntNext = '0;
    emit        = 1'b0;
    emitCode    = '0;
    emitParams  = '0;
    emitN       = '0;
    case (stateReg)
      ST_IDLE: begin
        if (pop) begin
          if (headByte == CHAR_ESC) begin
            stateNext = ST_ESC;
          end else begin
            emit     = 1'b1;
            emitCode = headByte;
          end
        end
      end
      ST_ESC: begin
        tickCntNext = tickSum;
        if (pop) begin
          tickCntNext = '0;
          if (headByte == CHAR_CSI_INTRO) begin
            stateNext = ST_CSI;
            for (int i = 0; i < MAX_PARAMS; i++) paramNext[i] = '0;
            idxNext = '0;
            anyNext = 1'b0;
          end else begin
            emit      = 1'b1;
            emitCode  = headByte;
            stateNext = ST_IDLE;
          end
        end else if (timedOut && !stall) begin
          // A lone ESC can only be released once the output register is free.
          emit      = 1'b1;
          emitCode  = CHAR_ESC;
          stateNext = ST_IDLE;
        end
      end
      ST_CSI: begin
        tickCntNext = tickSum;
        if (pop) begin
          tickCntNext = '0;
          if (isDigit(headByte)) begin
            anyNext = 1'b1;
            for (int i = 0; i < MAX_PARAMS; i++) begin
              if (NP_W'(i) == idxReg) paramNext[i] = accSat;
            end
          end else if (headByte == CHAR_SEMI) begin
            anyNext = 1'b1;
            if (idxReg < NP_W'(MAX_PARAMS)) idxNext = idxReg + NP_W'(1);
          end else if (isFinal(headByte)) begin
            stateNext = ST_IDLE;
            emit      = ~finDrop;
            emitCode  = finCode;
            if (finCmd) begin
              emitParams = cmdParams;
              emitN      = nGiven;
            end
          end else begin
            stateNext = ST_IDLE;
          end
        end else if (timedOut) begin
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stateReg      <= ST_IDLE;
      idxReg        <= '0;
      anyReg        <= 1'b0;
      tickCntReg    <= '0;
      tickSeenReg   <= 1'b0;
      for (int i = 0; i < MAX_PARAMS; i++) paramReg[i] <= '0;
      outValidReg   <= 1'b0;
      outCodeReg    <= '0;
      outParamsReg  <= '0;
      outNparamsReg <= '0;
    end else begin
      stateReg    <= stateNext;
      idxReg      <= idxNext;
      anyReg      <= anyNext;
      tickCntReg  <= tickCntNext;
      tickSeenReg <= tick;
      for (int i = 0; i < MAX_PARAMS; i++) paramReg[i] <= paramNext[i];
      if (!stall) begin
        outValidReg   <= emit;
        outCodeReg    <= emitCode;
        outParamsReg  <= emitParams;
        outNparamsReg <= emitN;
      end
    end
  end

endmodule

// File: tb/tb_ansi_csi_parser.sv
// Scoreboard bench for ansi_csi_parser: expected tokens are queued as bytes are sent
// and compared as the DUT hands them over.
module tb_ansi_csi_parser;
  import ansi_csi_parser_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tick = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        in_ovf;
  logic        out_valid;
  logic [7:0]  out_code;
  logic [15:0] out_params;
  logic [1:0]  out_nparams;

  typedef struct packed {
    logic [7:0]  code;
    logic [15:0] params;
    logic [1:0]  n;
  } tok_t;

  tok_t expQ[$];
  tok_t expTok;
  int   nCompared = 0;
  int   nMismatched = 0;
  int   ovfCount = 0;
  int   heldBad = 0;

  ansi_csi_parser dut (
    .clk        (clk),
    .resetn     (resetn),
    .tick       (tick),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .in_ovf     (in_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_params (out_params),
    .out_nparams(out_nparams)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expectTok(input logic [7:0] code, input logic [15:0] params, input logic [1:0] n);
    tok_t t;
    t.code = code;
    t.params = params;
    t.n = n;
    expQ.push_back(t);
  endtask

  task automatic sendByte(input logic [7:0] b);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) checkVal("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) sendByte(s[i]);
  endtask

  task automatic sendEsc(input string s);
    sendByte(CHAR_ESC);
    sendStr(s);
  endtask

  task automatic tickPulse();
    tick = 1'b1;
    repeat (2) @(posedge clk);
    #1 tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (expQ.size() != 0) begin
      checkVal("drain_timeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Token handover happens on the next rising edge; sample mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (in_ovf) ovfCount++;
      if (out_valid && out_ready) begin
        $display("token code=0x%02h params=0x%04h n=%0d", out_code, out_params, out_nparams);
        if (expQ.size() == 0) begin
          checkVal("unexpected_tok", 32'(out_code) | 32'h100, 32'd0);
        end else begin
          expTok = expQ.pop_front();
          checkVal("tok_code",    32'(out_code),    32'(expTok.code));
          checkVal("tok_params",  32'(out_params),  32'(expTok.params));
          checkVal("tok_nparams", 32'(out_nparams), 32'(expTok.n));
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_out_valid",   32'(out_valid),   32'd0);
    checkVal("rst_out_code",    32'(out_code),    32'd0);
    checkVal("rst_out_params",  32'(out_params),  32'd0);
    checkVal("rst_out_nparams", 32'(out_nparams), 32'd0);
    checkVal("rst_in_ovf",      32'(in_ovf),      32'd0);
    checkVal("rst_in_ready",    32'(in_ready),    32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;

    expectTok(CMD_GOTO, {8'd40, 8'd12}, 2'd2);
    sendEsc("[12;40H");
    waitDrain();

    expectTok(CMD_UP,   {8'd0, 8'd1}, 2'd0);
    expectTok(CMD_LEFT, {8'd0, 8'd5}, 2'd1);
    sendEsc("[A");
    sendEsc("[5D");
    waitDrain();

    expectTok(CMD_RIGHT, {8'd0, 8'd255}, 2'd1);
    sendEsc("[999C");
    waitDrain();

    expectTok(8'h61, 16'h0000, 2'd0);
    expectTok(8'hC1, 16'h0000, 2'd0);
    sendByte(8'h61);
    sendByte(8'hC1);
    waitDrain();

    // Lone ESC: nothing after one tick edge, CHAR_ESC after the second.
    sendByte(CHAR_ESC);
    repeat (4) @(posedge clk);
    #1;
    tickPulse();
    repeat (6) @(posedge clk);
    #1;
    expectTok(CHAR_ESC, 16'h0000, 2'd0);
    tickPulse();
    waitDrain();

    expectTok(8'h78, 16'h0000, 2'd0);
    sendByte(CHAR_ESC);
    sendByte(8'h78);
    waitDrain();

    expectTok(CMD_INSTOG,     {8'd0, 8'd2}, 2'd1);
    expectTok(CMD_DEL,        {8'd0, 8'd3}, 2'd1);
    expectTok(CMD_ERASE_LINE, {8'd0, 8'd2}, 2'd1);
    expectTok(CMD_CLS,        {8'd0, 8'd2}, 2'd1);
    sendEsc("[2~");
    sendEsc("[3~");
    sendEsc("[2K");
    sendEsc("[2J");
    waitDrain();

    expectTok(CMD_GOTO, {8'd4, 8'd3}, 2'd2);
    sendEsc("[3;4;5H");
    expectTok(8'h4A, 16'h0000, 2'd0);
    sendEsc("[5J");
    waitDrain();

`ifdef ANSI_SGR_EN
    expectTok(CMD_SGR, {8'd31, 8'd1}, 2'd2);
`endif
    expectTok(8'h7A, 16'h0000, 2'd0);
    sendEsc("[1;31m");
    sendByte(8'h7A);
    expectTok(8'h71, 16'h0000, 2'd0);
    sendEsc("[1!");
    sendByte(8'h71);
    waitDrain();

    // Backpressure: output holds 'a', FIFO takes b..e, 'f' is dropped.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) expectTok(8'(8'h61 + k), 16'h0000, 2'd0);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h61 + k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    heldBad = 0;
    repeat (14) begin
      @(negedge clk);
      if (!out_valid || out_code !== 8'h61) heldBad++;
    end
    checkVal("in_ready_full", 32'(in_ready), 32'd0);
    checkVal("held_stable",   32'(heldBad),  32'd0);
    checkVal("ovf_pulses",    32'(ovfCount), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    waitDrain();

    checkVal("idle_valid",  32'(out_valid),   32'd0);
    checkVal("queue_empty", 32'(expQ.size()), 32'd0);
    checkVal("ovf_total",   32'(ovfCount),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
